i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
// - I2C target (slave) giving an I2C host read/write access to the config/status register bank.
// - Sits beside the SPI wrapper, upstream of the bank; fills the currently tied-off sda_o/sda_oe path.
// - Inputs scl/sda_i come from the top-level 2-stage synchronizers and are sampled on clk.
// - Writes land in config_regs; reads return config or status bytes, selected by the pointer MSB.
// PARAMETERS
// - NUM_CFG     16     number of config regs (power of 2, 2..128)
// - NUM_STATUS  16     number of status regs (== NUM_CFG)
// - REG_WIDTH   8      register width; fixed at 8 (one I2C byte)
// - I2C_ADDR    7'h70  7-bit target address
// PORTS
// - clk          in   1                     system clock
// - rst_n        in   1                     asynchronous reset, active low
// - ena          in   1                     0 = FSM, shifters and regs hold; outputs hold
// - scl          in   1                     synchronized SCL
// - sda_i        in   1                     synchronized SDA
// - sda_o        out  1                     constant 0 (open-drain)
// - sda_oe       out  1                     1 = pull SDA low
// - config_regs  out  NUM_CFG*REG_WIDTH     register bank; byte n = [8n+7:8n]
// - status_regs  in   NUM_STATUS*REG_WIDTH  read-only status bytes
// BEHAVIOUR
// - Reset: state IDLE, sda_oe=0, config_regs=0, pointer=0, shifters=0, scl/sda history regs=1.
// - Edge detect uses 1-clk history of scl/sda.
//   - START: scl=1 and sda 1->0. STOP: scl=1 and sda 0->1.
//   - Bits sampled on scl rise; sda_oe changes only on the clk after scl fall.
// - STOP from any state -> IDLE, sda_oe=0 next clk.
// - START from any state, incl. repeated START -> ADDR, bit count cleared; pointer kept.
// - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
//   - ADDR: shift 8 bits MSB first. Match {I2C_ADDR,R/W}? -> ADDR_ACK, else IDLE with no ACK.
//   - ADDR_ACK: drive low for one SCL period.
//     - R/W=0 -> PTR.
//     - R/W=1 -> RDATA; load byte[pointer] at the ACK-releasing scl fall.
//   - PTR: 8 bits, then PTR_ACK (ACK driven).
//     - pointer = byte[$clog2(NUM_CFG)-1:0]; bank select = byte[7].
//     - Then WDATA.
//   - WDATA: 8 bits, then WDATA_ACK (ACK driven).
//     - config_regs[pointer] written on the clk after the 8th scl rise, even if bank=1.
//     - Then pointer+1 and back to WDATA.
//   - RDATA: drive MSB first; sda_oe = ~bit.
//     - After 8 bits release SDA -> RDATA_ACK; sample host ACK on scl rise.
//     - ACK (0) -> pointer+1, load next byte, RDATA.
//     - NACK (1) -> IDLE, SDA released.
//   - Read byte: bank=0 -> config_regs[pointer]; bank=1 -> status_regs[pointer].
// - Pointer increment wraps modulo NUM_CFG (NUM_CFG-1 -> 0); bank bit unchanged.
// - Write collides with reset? Reset wins. Mid-transfer rst_n low -> full reset, SDA released at once.
// - Address NACK: target stays silent until next START; no reg changes.
// - Requires clk >= 16x SCL frequency (>= 20x with filter).
// CONFIGURATION
// - I2C_GLITCH_FILTER_EN defined:
//   - scl/sda each pass a 3-sample majority filter before edge detection.
//   - Adds 2 clk latency; rejects single-clk pulses.
// - Not defined: raw synchronized inputs feed edge detection directly; 1-clk glitches are seen as edges.
// TESTING
// - Write: START,0xE0,0x00,0x3C,STOP -> three ACKs; config byte0=0x3C; all other regs 0.
// - Burst write + wrap: START,0xE0,0x0F,0x11,0x22,STOP -> cfg[15]=0x11, cfg[0]=0x22.
// - Status read: status[0..1]=CA,10.
//   - START,0xE0,0x80, rSTART,0xE1, read 2 (ACK, then NACK), STOP.
//   - Host receives 0xCA,0x10; SDA released after NACK.
// - Wrong address: START,0xA0,... -> no ACK (sda_oe stays 0); config unchanged.
// - Reset mid-read: rst_n low during 4th data bit -> sda_oe=0 same cycle, config_regs=0, FSM IDLE.
// - With I2C_GLITCH_FILTER_EN: 1-clk sda low pulse while scl=1 -> no START detected, state stays IDLE.

Source files
------------

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target that gives an I2C host byte-wide read/write access to the
// config/status register bank.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ena                 0 = all state (FSM, shifters, regs, edge history) holds
//   scl, sda_i          synchronized bus inputs, sampled on clk
//   sda_o, sda_oe       open-drain SDA drive: sda_o is always 0, sda_oe=1 pulls SDA low
//   config_regs         host-writable register bank, byte n = [8n+7:8n]
//   status_regs         read-only status bytes, same layout
//
// Build option: define I2C_GLITCH_FILTER_EN to pass scl/sda through a 3-sample majority
// filter ahead of edge detection (2 clk extra latency, single-clk pulses rejected).
// Pointer byte: bits [$clog2(NUM_CFG)-1:0] select the register, bit 7 selects the bank
// returned by reads (0 = config, 1 = status). Writes always land in config_regs.
module i2c_target_regs #(
  parameter int unsigned NUM_CFG    = 16,
  parameter int unsigned NUM_STATUS = 16,
  parameter int unsigned REG_WIDTH  = 8,
  parameter logic [6:0]  I2C_ADDR   = 7'h70
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic                            scl,
  input  logic                            sda_i,
  output logic                            sda_o,
  output logic                            sda_oe,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs
);

  localparam int unsigned PtrW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdataAck
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic                 bank_q, bank_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 wr_pend_q, wr_pend_d;
  logic [REG_WIDTH-1:0] cfg_q [NUM_CFG];
  logic [REG_WIDTH-1:0] status_arr [NUM_STATUS];

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, rd_byte;

  //--------------------------------------------------------------------------
  // Optional input filter
  //--------------------------------------------------------------------------
`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
    end else if (ena) begin
      scl_hist_q <= {scl_hist_q[1:0], scl};
      sda_hist_q <= {sda_hist_q[1:0], sda_i};
    end
  end

  assign scl_f = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                 (scl_hist_q[1] & scl_hist_q[2]);
  assign sda_f = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                 (sda_hist_q[1] & sda_hist_q[2]);
`else
  assign scl_f = scl;
  assign sda_f = sda_i;
`endif

  //--------------------------------------------------------------------------
  // Bus event detection (1-clk history)
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else if (ena) begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  // Byte including the bit being sampled on this scl rise.
  assign rx_byte = {shift_q[6:0], sda_f};

  for (genvar i = 0; i < NUM_STATUS; i++) begin : g_status
    assign status_arr[i] = status_regs[i*REG_WIDTH +: REG_WIDTH];
  end

  assign rd_byte = bank_q ? status_arr[ptr_q] : cfg_q[ptr_q];

  //--------------------------------------------------------------------------
  // Protocol FSM
  //--------------------------------------------------------------------------
  // In the *Ack states the target enters on the 8th scl rise; the first scl fall starts
  // driving the ACK (sda_oe_q still 0), the second one ends it (sda_oe_q already 1).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    bank_d    = bank_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    wr_pend_d = wr_pend_q;

    if (ena) begin
      wr_pend_d = 1'b0;
      // Write lands one clk after the 8th data rise; pointer advances with it.
      if (wr_pend_q) ptr_d = ptr_q + PtrW'(1);

      if (stop_det) begin
        state_d  = StIdle;
        sda_oe_d = 1'b0;
        cnt_d    = '0;
      end else if (start_det) begin
        state_d  = StAddr;
        sda_oe_d = 1'b0;
        cnt_d    = '0;
      end else begin
        unique case (state_q)
          StIdle: begin
          end

          StAddr: begin
            if (scl_rise) begin
              shift_d = rx_byte;
              cnt_d   = cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                if (rx_byte[7:1] == I2C_ADDR) begin
                  state_d = StAddrAck;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = StIdle;
                end
              end
            end
          end

          StAddrAck: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_d = 1'b1;
              end else begin
                cnt_d = '0;
                if (rw_q) begin
                  state_d  = StRdata;
                  shift_d  = rd_byte;
                  sda_oe_d = ~rd_byte[7];
                end else begin
                  state_d  = StPtr;
                  sda_oe_d = 1'b0;
                end
              end
            end
          end

          StPtr: begin
            if (scl_rise) begin
              shift_d = rx_byte;
              cnt_d   = cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                state_d = StPtrAck;
                ptr_d   = rx_byte[PtrW-1:0];
                bank_d  = rx_byte[7];
              end
            end
          end

          StPtrAck, StWdataAck: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_d = 1'b1;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = StWdata;
                cnt_d    = '0;
              end
            end
          end

          StWdata: begin
            if (scl_rise) begin
              shift_d = rx_byte;
              cnt_d   = cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                state_d   = StWdataAck;
                wr_pend_d = 1'b1;
              end
            end
          end

          StRdata: begin
            if (scl_rise) begin
              cnt_d = cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_d = 1'b0;
                state_d  = StRdataAck;
                cnt_d    = '0;
              end else begin
                shift_d  = {shift_q[6:0], 1'b0};
                sda_oe_d = ~shift_q[6];
              end
            end
          end

          StRdataAck: begin
            if (scl_rise) begin
              if (sda_f) state_d = StIdle;             // host NACK ends the read
              else       ptr_d   = ptr_q + PtrW'(1);
            end else if (scl_fall) begin
              // Only reachable after an ACK rise, so ptr_q already points at the next byte.
              state_d  = StRdata;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
              cnt_d    = '0;
            end
          end

          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      bank_q    <= 1'b0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      bank_q    <= bank_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
    end else if (ena && wr_pend_q) begin
      cfg_q[ptr_q] <= shift_q;
    end
  end

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
    assign config_regs[i*REG_WIDTH +: REG_WIDTH] = cfg_q[i];
  end

  assign sda_o  = 1'b0;
  assign sda_oe = sda_oe_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: an I2C host model drives the bus; every scl pulse pushes the
// expected target drive (sda_oe) into a scoreboard queue that a monitor pops on each pulse.
// Register contents are predicted by a byte-array model of the bank and pointer.
module tb_i2c_target_regs;

  localparam int NCFG = 16;
  localparam int Q    = 6;  // clk per quarter SCL period (SCL = 24 clk)

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst_n, ena, scl_h, sda_h, sda_bus;
  logic sda_o, sda_oe;
  logic [NCFG*8-1:0] config_regs, status_regs;

  always #5 clk = ~clk;

  // Open-drain bus: host and target both pull low.
  assign sda_bus = sda_h & ~sda_oe;

  i2c_target_regs #(
    .NUM_CFG   (NCFG),
    .NUM_STATUS(NCFG),
    .REG_WIDTH (8),
    .I2C_ADDR  (7'h70)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .scl        (scl_h),
    .sda_i      (sda_bus),
    .sda_o      (sda_o),
    .sda_oe     (sda_oe),
    .config_regs(config_regs),
    .status_regs(status_regs)
  );

  // Reference model
  logic [7:0] cfg_m [NCFG];
  logic [7:0] st_m  [NCFG];
  int         ptr_m;
  logic       bank_m;

  always_comb begin
    status_regs = '0;
    for (int i = 0; i < NCFG; i++) status_regs[8*i +: 8] = st_m[i];
  end

  // Scoreboard
  logic  exp_oe_q [$];
  string exp_nm_q [$];
  event  bit_ev;
  int    vectors = 0;
  int    miscompares = 0;
  bq_t   dq;

  task automatic check1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_cfg(input string nm);
    logic [NCFG*8-1:0] e;
    for (int i = 0; i < NCFG; i++) e[8*i +: 8] = cfg_m[i];
    vectors++;
    if (config_regs !== e) begin
      miscompares++;
      $display("FAIL %s: config_regs=%h expected %h", nm, config_regs, e);
    end
  endtask

  task automatic monitor();
    logic  e;
    string nm;
    forever begin
      @(bit_ev);
      if (exp_oe_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_bit: sda_oe=%b with no expectation queued", sda_oe);
      end else begin
        e  = exp_oe_q.pop_front();
        nm = exp_nm_q.pop_front();
        check1(nm, sda_oe, e);
      end
    end
  endtask

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  // One SCL pulse with host SDA level b; target drive expected at the rise is exp_oe.
  task automatic bit_clk(input logic b, input logic exp_oe, input string nm);
    sda_h = b;
    wait_q();
    exp_oe_q.push_back(exp_oe);
    exp_nm_q.push_back(nm);
    scl_h = 1'b1;
    ->bit_ev;
    wait_q(2);
    scl_h = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    sda_h = 1'b1;
    wait_q();
    scl_h = 1'b1;
    wait_q();
    sda_h = 1'b0;
    wait_q();
    scl_h = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    sda_h = 1'b0;
    wait_q();
    scl_h = 1'b1;
    wait_q();
    sda_h = 1'b1;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack_exp, input string nm);
    for (int i = 7; i >= 0; i--) bit_clk(b[i], 1'b0, $sformatf("%s_%02h_b%0d", nm, b, i));
    bit_clk(1'b1, ack_exp, $sformatf("%s_%02h_ack", nm, b));
  endtask

  task automatic recv_byte(input logic [7:0] exp_b, input logic last);
    for (int i = 7; i >= 0; i--) bit_clk(1'b1, ~exp_b[i], $sformatf("rdata_%02h_b%0d", exp_b, i));
    bit_clk(last, 1'b0, "host_ack_slot");
  endtask

  task automatic set_ptr_model(input logic [7:0] p);
    ptr_m  = int'(p) % NCFG;
    bank_m = p[7];
  endtask

  task automatic txn_write(input logic [6:0] a, input logic [7:0] p, input bq_t d,
                           input logic live);
    logic m;
    m = live && (a == 7'h70);
    i2c_start();
    send_byte({a, 1'b0}, m, "addr_w");
    send_byte(p, m, "ptr");
    if (m) set_ptr_model(p);
    foreach (d[k]) begin
      send_byte(d[k], m, "wdata");
      if (m) begin
        cfg_m[ptr_m] = d[k];
        ptr_m = (ptr_m + 1) % NCFG;
      end
    end
    i2c_stop();
  endtask

  task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic [7:0] e;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'hE0, 1'b1, "addr_w");
      send_byte(p, 1'b1, "ptr");
      set_ptr_model(p);
      i2c_start();
    end
    send_byte(8'hE1, 1'b1, "addr_r");
    for (int k = 0; k < n; k++) begin
      e = bank_m ? st_m[ptr_m] : cfg_m[ptr_m];
      recv_byte(e, k == n - 1);
      if (k != n - 1) ptr_m = (ptr_m + 1) % NCFG;
    end
    i2c_stop();
  endtask

  initial begin
    int         kind;
    logic [6:0] a;
    logic [7:0] p;

    for (int i = 0; i < NCFG; i++) begin
      cfg_m[i] = 8'h00;
      st_m[i]  = 8'h00;
    end
    ptr_m  = 0;
    bank_m = 1'b0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    scl_h  = 1'b1;
    sda_h  = 1'b1;

    fork
      monitor();
    join_none

    repeat (4) @(negedge clk);
    check1("reset_sda_oe", sda_oe, 1'b0);
    check1("reset_sda_o", sda_o, 1'b0);
    check_cfg("reset_config");
    rst_n = 1'b1;
    wait_q();

    // Single write
    dq = '{8'h3C};
    txn_write(7'h70, 8'h00, dq, 1'b1);
    check_cfg("write_byte0");

    // Burst write wrapping 15 -> 0
    dq = '{8'h11, 8'h22};
    txn_write(7'h70, 8'h0F, dq, 1'b1);
    check_cfg("burst_wrap");

    // Status read with repeated START
    st_m[0] = 8'hCA;
    st_m[1] = 8'h10;
    txn_read(1'b1, 8'h80, 2);

    // Wrong address: silent, no register change
    dq = '{8'h55, 8'h66};
    txn_write(7'h50, 8'h02, dq, 1'b1);
    check_cfg("wrong_addr");

    // Whole transaction while ena=0: nothing acknowledged or written
    ena = 1'b0;
    dq = '{8'h99};
    txn_write(7'h70, 8'h05, dq, 1'b0);
    ena = 1'b1;
    wait_q();
    check_cfg("ena_low_hold");

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      if (t % 6 == 0) begin
        for (int i = 0; i < NCFG; i++) st_m[i] = 8'($urandom_range(0, 255));
        wait_q();
      end
      kind = int'($urandom_range(0, 9));
      p    = 8'($urandom_range(0, 255));
      dq.delete();
      if (kind < 4) begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) dq.push_back(8'($urandom_range(0, 255)));
        txn_write(7'h70, p, dq, 1'b1);
      end else if (kind < 8) begin
        txn_read(1'($urandom_range(0, 1)), p, int'($urandom_range(1, 4)));
      end else begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h70) a = 7'h71;
        dq.push_back(8'($urandom_range(0, 255)));
        txn_write(a, p, dq, 1'b1);
      end
      if (t % 4 == 3) check_cfg($sformatf("random_t%0d", t));
    end
    check_cfg("random_end");

`ifdef I2C_GLITCH_FILTER_EN
    // One-clk SDA low pulse while SCL high must not look like a START
    @(negedge clk);
    sda_h = 1'b0;
    @(negedge clk);
    sda_h = 1'b1;
    wait_q();
    scl_h = 1'b0;
    wait_q();
    send_byte(8'hE0, 1'b0, "glitch_no_start");
    i2c_stop();
`endif

    // Reset during the 4th data bit of a status read (0xCA: 4th bit is 0, target drives)
    st_m[0] = 8'hCA;
    wait_q();
    i2c_start();
    send_byte(8'hE0, 1'b1, "addr_w");
    send_byte(8'h80, 1'b1, "ptr");
    set_ptr_model(8'h80);
    i2c_start();
    send_byte(8'hE1, 1'b1, "addr_r");
    for (int i = 7; i >= 5; i--) bit_clk(1'b1, ~st_m[0][i], $sformatf("rst_rd_b%0d", i));
    sda_h = 1'b1;
    wait_q();
    exp_oe_q.push_back(1'b1);
    exp_nm_q.push_back("rst_rd_b4_driven");
    scl_h = 1'b1;
    ->bit_ev;
    wait_q();
    rst_n = 1'b0;
    #1;
    check1("reset_releases_sda", sda_oe, 1'b0);
    for (int i = 0; i < NCFG; i++) cfg_m[i] = 8'h00;
    ptr_m  = 0;
    bank_m = 1'b0;
    check_cfg("reset_clears_config");
    @(negedge clk);
    scl_h = 1'b0;
    wait_q();
    rst_n = 1'b1;
    wait_q();
    // Without a START the target must stay idle
    send_byte(8'hE0, 1'b0, "post_reset_idle");
    i2c_stop();

    dq = '{8'hA5, 8'h5A};
    txn_write(7'h70, 8'h07, dq, 1'b1);
    check_cfg("post_reset_write");
    txn_read(1'b1, 8'h07, 2);

    wait_q(2);
    vectors++;
    if (exp_oe_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_oe_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
